// File: rtl/random_engine_pkg.sv
// Shared types and helpers for the random engine arbiter.
package random_engine_pkg;

  typedef enum logic {
    STATE_IDLE  = 1'b0,
    STATE_BURST = 1'b1
  } state_e;

  // Index width for an n-entry requester set; never narrower than one bit.
  function automatic int unsigned id_w(input int unsigned n);
    return (n > 1) ? unsigned'($clog2(n)) : 1;
  endfunction

endpackage

// File: rtl/register.sv
// Plain D register with synchronous active-high reset to a parameterised value.
module register #(
  parameter int unsigned      Width    = 1,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  // Capture next state; reset wins.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_o <= ResetVal;
    end else begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr_i, wrapping.
module rr_arbiter
  import random_engine_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IdW  = id_w(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IdW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IdW-1:0]  idx_o,
  output logic            valid_o
);

  // Scan NREQ positions starting at the pointer; the first hit wins.
  always_comb begin
    logic           found;
    int unsigned    k;
    logic [IdW-1:0] kk;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      k = 32'(ptr_i) + off;
      if (k >= NREQ) k = k - NREQ;
      kk = IdW'(k);
      if (!found && req_i[kk]) begin
        found     = 1'b1;
        gnt_o[kk] = 1'b1;
        idx_o     = kk;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/random_engine_arbiter.sv
// Round-robin sharing of one LFSR datapath among NREQ burst requesters.
// The LFSR is advanced exactly once per word accepted by the granted requester.
module random_engine_arbiter
  import random_engine_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned DATA_W = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NREQ-1:0]       req_val_i,
  input  logic [NREQ*LEN_W-1:0] req_len_i,
  output logic [NREQ-1:0]       req_rdy_o,
  output logic [NREQ-1:0]       resp_val_o,
  input  logic [NREQ-1:0]       resp_rdy_i,
  output logic [DATA_W-1:0]     resp_data_o,
  input  logic                  flush_i,
  input  logic [DATA_W-1:0]     lfsr_out_i,
  output logic                  lfsr_en_o,
  output logic                  busy_o,
  output logic [id_w(NREQ)-1:0] grant_id_o
);

  localparam int unsigned IdW = id_w(NREQ);

  state_e         state_q, state_d;
  logic [0:0]     state_raw_q;
  logic [IdW-1:0] ptr_q, ptr_d;
  logic [IdW-1:0] id_q, id_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;

  logic [NREQ-1:0]  win_gnt;
  logic [IdW-1:0]   win_idx;
  logic             win_valid;
  logic [LEN_W-1:0] win_len;
  logic             accept;
  logic             fire;

  function automatic logic [IdW-1:0] wrap_inc(input logic [IdW-1:0] i);
    if (i == IdW'(NREQ - 1)) return '0;
    return i + IdW'(1);
  endfunction

  // State register and datapath registers.
  register #(.Width(1), .ResetVal(1'b0)) u_state_reg (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (state_d),
    .q_o   (state_raw_q)
  );
  assign state_q = state_e'(state_raw_q);

  register #(.Width(IdW), .ResetVal('0)) u_ptr_reg (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (ptr_d),
    .q_o   (ptr_q)
  );

  register #(.Width(IdW), .ResetVal('0)) u_id_reg (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (id_d),
    .q_o   (id_q)
  );

  register #(.Width(LEN_W), .ResetVal('0)) u_cnt_reg (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (cnt_d),
    .q_o   (cnt_q)
  );

  rr_arbiter #(
    .NREQ (NREQ),
    .IdW  (IdW)
  ) u_rr_arbiter (
    .req_i   (req_val_i),
    .ptr_i   (ptr_q),
    .gnt_o   (win_gnt),
    .idx_o   (win_idx),
    .valid_o (win_valid)
  );

  assign win_len = req_len_i[win_idx*LEN_W +: LEN_W];
  assign accept  = (state_q == STATE_IDLE) && win_valid && !flush_i;
  // flush outranks a word handshake in the same cycle.
  assign fire    = (state_q == STATE_BURST) && resp_rdy_i[id_q] && !flush_i;

  // Next-state logic: grant in IDLE, count words or abort in BURST.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    case (state_q)
      STATE_IDLE: begin
        if (accept) begin
          id_d  = win_idx;
          cnt_d = win_len;
          if (win_len != '0) begin
            state_d = STATE_BURST;
          end else begin
            // Zero-length request is consumed without words but still rotates priority.
            ptr_d = wrap_inc(win_idx);
          end
        end
      end
      STATE_BURST: begin
        if (flush_i) begin
          state_d = STATE_IDLE;
          ptr_d   = wrap_inc(id_q);
          cnt_d   = '0;
        end else if (fire) begin
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            state_d = STATE_IDLE;
            ptr_d   = wrap_inc(id_q);
          end
        end
      end
      default: state_d = STATE_IDLE;
    endcase
  end

  // Output decode from current state and live handshake inputs.
  always_comb begin
    req_rdy_o  = '0;
    resp_val_o = '0;
    lfsr_en_o  = 1'b0;
    busy_o     = 1'b0;
    case (state_q)
      STATE_IDLE: begin
        if (!flush_i) req_rdy_o = win_gnt;
      end
      STATE_BURST: begin
        busy_o    = 1'b1;
        lfsr_en_o = fire;
        if (!flush_i) resp_val_o[id_q] = 1'b1;
      end
      default: ;
    endcase
  end

  assign resp_data_o = lfsr_out_i;
  assign grant_id_o  = id_q;

endmodule

// File: tb/tb_random_engine_arbiter.sv
// Randomised and directed bench for random_engine_arbiter against a transaction-level model.
module tb_random_engine_arbiter;

  localparam int NREQ   = 4;
  localparam int LEN_W  = 8;
  localparam int DATA_W = 16;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_val;
  logic [NREQ*LEN_W-1:0] req_len;
  logic [NREQ-1:0]       req_rdy;
  logic [NREQ-1:0]       resp_val;
  logic [NREQ-1:0]       resp_rdy;
  logic [DATA_W-1:0]     resp_data;
  logic                  flush;
  logic [DATA_W-1:0]     lfsr_val;
  logic                  lfsr_en;
  logic                  busy;
  logic [1:0]            grant_id;

  always #5 clk = ~clk;

  random_engine_arbiter #(
    .NREQ   (NREQ),
    .LEN_W  (LEN_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_val_i   (req_val),
    .req_len_i   (req_len),
    .req_rdy_o   (req_rdy),
    .resp_val_o  (resp_val),
    .resp_rdy_i  (resp_rdy),
    .resp_data_o (resp_data),
    .flush_i     (flush),
    .lfsr_out_i  (lfsr_val),
    .lfsr_en_o   (lfsr_en),
    .busy_o      (busy),
    .grant_id_o  (grant_id)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Model: whether a burst is in progress, who owns it, words left, priority start, last grantee.
  int m_burst = 0, m_owner = 0, m_rem = 0, m_prio = 0, m_id = 0;
  int sb_len = 0, sb_cnt = 0;
  int total_words = 0;
  int e_win, e_fire;
  logic [NREQ-1:0] e_rdy, e_val;

  function automatic int len_of(input int k);
    logic [NREQ*LEN_W-1:0] v;
    v = req_len;
    return int'(v[k*LEN_W +: LEN_W]);
  endfunction

  task automatic model_eval();
    e_win = -1;
    for (int off = 0; off < NREQ; off++) begin
      int k;
      k = (m_prio + off) % NREQ;
      if (e_win < 0 && req_val[k]) e_win = k;
    end
    e_rdy  = '0;
    e_val  = '0;
    e_fire = 0;
    if (m_burst == 0) begin
      if (e_win >= 0 && !flush) e_rdy[e_win] = 1'b1;
    end else begin
      if (!flush) e_val[m_owner] = 1'b1;
      e_fire = (!flush && resp_rdy[m_owner]) ? 1 : 0;
    end
  endtask

  task automatic model_next();
    if (rst) begin
      m_burst = 0; m_owner = 0; m_rem = 0; m_prio = 0; m_id = 0;
    end else if (m_burst == 0) begin
      if (e_win >= 0 && !flush) begin
        m_id = e_win;
        if (len_of(e_win) == 0) begin
          m_prio = (e_win + 1) % NREQ;
        end else begin
          m_burst = 1; m_owner = e_win; m_rem = len_of(e_win);
          sb_len  = m_rem; sb_cnt = 0;
        end
      end
    end else if (flush) begin
      m_burst = 0;
      m_prio  = (m_owner + 1) % NREQ;
    end else if (e_fire != 0) begin
      m_rem--;
      if (m_rem == 0) begin
        m_burst = 0;
        m_prio  = (m_owner + 1) % NREQ;
        check("burst_words", sb_cnt, sb_len);
      end
    end
  endtask

  // One clock: compare at the falling edge, then advance model and LFSR past the rising edge.
  task automatic run_cycle();
    int fired;
    @(negedge clk);
    model_eval();
    check("req_rdy",   32'(req_rdy),   32'(e_rdy));
    check("resp_val",  32'(resp_val),  32'(e_val));
    check("lfsr_en",   32'(lfsr_en),   32'(e_fire));
    check("busy",      32'(busy),      32'(m_burst));
    check("grant_id",  32'(grant_id),  32'(m_id));
    check("resp_data", 32'(resp_data), 32'(lfsr_val));
    if (m_burst != 0 && (resp_val & resp_rdy) != '0) sb_cnt++;
    fired = e_fire;
    model_next();
    @(posedge clk);
    #1;
    if (!rst && fired != 0) begin
      lfsr_val = {lfsr_val[14:0], lfsr_val[15] ^ lfsr_val[13] ^ lfsr_val[12] ^ lfsr_val[10]};
      total_words++;
    end
  endtask

  task automatic drive(input logic [NREQ-1:0] v, input int len, input logic [NREQ-1:0] r,
                       input logic f, input logic rs);
    req_val  = v;
    req_len  = {NREQ{LEN_W'(len)}};
    resp_rdy = r;
    flush    = f;
    rst      = rs;
  endtask

  initial begin
    lfsr_val = 16'hACE1;
    drive('0, 0, '0, 1'b0, 1'b1);
    run_cycle();
    // Reset state with quiet inputs.
    drive('0, 0, '0, 1'b0, 1'b0);
    run_cycle();

    // Single request of three words.
    drive(4'b0001, 3, 4'b1111, 1'b0, 1'b0);
    run_cycle();
    drive('0, 3, 4'b1111, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) run_cycle();
    check("single_words", total_words, 3);

    // All four requesting one-word bursts.
    drive(4'b1111, 1, 4'b1111, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) run_cycle();
    drive('0, 1, 4'b1111, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) run_cycle();

    // Backpressure on a two-word burst.
    drive(4'b0100, 2, 4'b1111, 1'b0, 1'b0);
    run_cycle();
    req_val = '0;
    for (int i = 0; i < 4; i++) begin
      resp_rdy = (i == 1 || i == 2) ? 4'b0000 : 4'b1111;
      run_cycle();
    end
    run_cycle();

    // Zero-length request.
    drive(4'b0010, 0, 4'b1111, 1'b0, 1'b0);
    run_cycle();
    req_val = '0;
    for (int i = 0; i < 3; i++) run_cycle();

    // Flush after two words of five, with competing requesters waiting.
    drive(4'b0001, 5, 4'b1111, 1'b0, 1'b0);
    run_cycle();
    req_val = 4'b0011;
    run_cycle();
    run_cycle();
    flush = 1'b1;
    run_cycle();
    flush = 1'b0;
    for (int i = 0; i < 4; i++) run_cycle();
    req_val = '0;
    for (int i = 0; i < 4; i++) run_cycle();

    // Reset mid-burst, then a fresh request.
    drive(4'b1000, 6, 4'b1111, 1'b0, 1'b0);
    run_cycle();
    req_val = '0;
    run_cycle();
    run_cycle();
    rst = 1'b1;
    run_cycle();
    rst = 1'b0;
    run_cycle();
    drive(4'b0100, 2, 4'b1111, 1'b0, 1'b0);
    run_cycle();
    req_val = '0;
    for (int i = 0; i < 4; i++) run_cycle();

    // Random traffic.
    for (int c = 0; c < 4000; c++) begin
      req_val = ($urandom_range(0, 1) == 0) ? '0 : NREQ'($urandom_range(0, 15));
      for (int k = 0; k < NREQ; k++) begin
        req_len[k*LEN_W +: LEN_W] = ($urandom_range(0, 15) == 0) ?
          LEN_W'($urandom_range(0, 40)) : LEN_W'($urandom_range(0, 5));
      end
      resp_rdy = NREQ'($urandom_range(0, 15));
      flush    = ($urandom_range(0, 24) == 0);
      rst      = ($urandom_range(0, 299) == 0);
      run_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
